mem_load_queue_stage: RTL and testbench
=======================================

Name: mem_load_queue_stage

Overview:
- Parametrised successor to the single-entry MIPS memory stage.
- Holds up to DEPTH in-order instructions between pre-memory and writeback, so several loads can be outstanding on the data port.
- Performs byte/half/word/LWL/LWR extraction when each response returns, and retires entries to WB strictly in program order.
- Supports pipeline flush while load responses are still in flight.

Parameters:
DEPTH, 2, queue entries; power of two, >=2.
OP_W, 20, width of the control-op bundle passed through to WB.
RESET_PC, 32'hbfc00000, value of stored pc fields after reset.

Ports:
clk  in  1  clock
resetn  in  1  reset; synchronous, active-low
in_valid  in  1  upstream entry valid
in_allowin  out  1  stage can accept an entry this cycle
in_pc  in  32  pc of incoming instruction
in_inst  in  32  instruction code
in_op  in  OP_W  control ops; bits [6:4] = load mode
in_dest  in  5  destination register number
in_value  in  32  alu result / effective address (bits [1:0] select lane)
in_ld_value  in  32  old rt value for LWL/LWR merge
resp_valid  in  1  data-port load response valid (in order, one per load)
resp_rdata  in  32  load response data
out_valid  out  1  head entry complete, presented to WB
out_pc  out  32  head pc
out_inst  out  32  head instruction
out_op  out  OP_W  head control ops
out_dest  out  5  head destination
out_value  out  32  head final result
wb_allowin  in  1  WB accepts this cycle
flush  in  1  discard all queued entries (exception/eret)

Behaviour:
- Storage: circular buffer of DEPTH entries, with head/tail pointers and count (log2(DEPTH)+1 bits). Per entry: pc, inst, op, dest, value, ld_value, done.
- Load mode = op[6:4]:
  - 000 non-load
  - 001 LW
  - 010 LWL
  - 011 LWR
  - 100 LBU
  - 101 LHU
  - 110 LB
  - 111 LH
- Enqueue when in_valid && in_allowin. in_allowin = !flush && (count<DEPTH || (out_valid && wb_allowin)); full plus retire in the same cycle is allowed.
- Non-load entries are written with done=1 and value=in_value. Load entries are written with done=0.
- Pending pointer tracks the oldest load with done=0. On resp_valid, that entry gets value = extract(mode, value[1:0], resp_rdata, ld_value) and done=1; the pointer then advances to the next undone load.
- Extraction rules:
  - LWL a=0..3 → {rdata[8a+7:0], ld[23-8a:0]}; a=3 gives rdata.
  - LWR a=0..3 → {ld[31:32-8a], rdata[31:8a]}; a=0 gives rdata.
  - LB/LBU select byte a, sign- or zero-extended.
  - LH/LHU select half a[1], sign- or zero-extended.
- resp_valid with no pending load and discard counter 0 is ignored; no state change.
- Output: out_* are driven from the head entry; out_valid = count!=0 && head.done. Retire when out_valid && wb_allowin.
- Latency:
  - Non-load enqueued in cycle N appears at out_valid in cycle N+1 (queue otherwise empty).
  - Load whose response arrives in cycle M appears at out_valid in cycle M+1.
- Enqueue, response and retire can occur in the same cycle; count updates by +1/0/-1 accordingly.
- Flush (synchronous):
  - Empties the queue (count=0, head=tail) and sets out_valid=0 next cycle.
  - discard_cnt += number of undone loads, minus 1 if resp_valid in the same cycle.
  - While discard_cnt>0, each resp_valid decrements it and is dropped.
  - Enqueue is blocked during the flush cycle only.
- Reset: all entries cleared, done=0, pc=RESET_PC, other fields 0, count=0, discard_cnt=0. Hence out_valid=0, in_allowin=1, out_pc=RESET_PC, out_value=0.
- Reset mid-operation drops everything, including in-flight responses; the bus is reset with the core.

Optional Feature:
MEM_RESP_BYPASS_EN:
- Defined: when the pending load is the head entry and resp_valid=1, out_value is the extracted response combinationally and out_valid=1 in the same cycle. If wb_allowin=1, the entry retires that cycle; load-to-WB latency is 0.
- Undefined: responses are always registered first; latency is +1 as above. There is no combinational path from resp_* to out_*.

Test Plan:
- Non-load: reset; enqueue addu value=32'h1234 in cycle 1, wb_allowin=1 → out_valid in cycle 2 with out_value=32'h1234; count returns to 0 in cycle 3.
- Byte/half extraction, resp_rdata=32'h8899aabb:
  - LB addr[1:0]=2 → 32'hffffff99.
  - LBU addr[1:0]=2 → 32'h00000099.
  - LH addr[1:0]=2 → 32'hffff8899.
  - LHU addr[1:0]=0 → 32'h0000aabb.
- Unaligned merge with ld_value=32'h11223344, rdata=32'haabbccdd:
  - LWL a=1 → 32'hccdd3344.
  - LWR a=2 → 32'h1122aabb.
- Ordering with wb_allowin=1:
  - Enqueue LW, addu, LW back-to-back (DEPTH=4); hold resp for 3 cycles → out_valid stays 0 because the head is undone.
  - Response 1 → LW and addu retire in consecutive cycles.
  - Response 2 → second LW retires.
- Full + backpressure, DEPTH=2: two non-loads with wb_allowin=0 → in_allowin=0. Raise wb_allowin with in_valid=1 → retire and enqueue in the same cycle; count stays 2.
- Flush with 2 pending loads and resp_valid=0 → discard_cnt=2. The next two responses are dropped. A new LW enqueued after the flush receives the third response with the correct value.

Source files
------------

// File: rtl/mem_load_queue_stage.sv
// In-order memory-stage queue: holds up to DEPTH entries, extracts load data on response, retires to WB in program order.
// Optional feature macro MEM_RESP_BYPASS_EN: forward a response straight to out_* when the pending load is the head entry.
module mem_load_queue_stage #(
    parameter int          DEPTH    = 2,
    parameter int          OP_W     = 20,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_allowin,
    input  logic [31:0]     in_pc,
    input  logic [31:0]     in_inst,
    input  logic [OP_W-1:0] in_op,
    input  logic [4:0]      in_dest,
    input  logic [31:0]     in_value,
    input  logic [31:0]     in_ld_value,
    input  logic            resp_valid,
    input  logic [31:0]     resp_rdata,
    output logic            out_valid,
    output logic [31:0]     out_pc,
    output logic [31:0]     out_inst,
    output logic [OP_W-1:0] out_op,
    output logic [4:0]      out_dest,
    output logic [31:0]     out_value,
    input  logic            wb_allowin,
    input  logic            flush
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    // Responses still owed for flushed loads; sized for repeated flushes ahead of a slow bus.
    localparam int DISC_W = 8;

    logic [31:0]       pc_q [DEPTH], pc_d [DEPTH];
    logic [31:0]       inst_q [DEPTH], inst_d [DEPTH];
    logic [OP_W-1:0]   op_q [DEPTH], op_d [DEPTH];
    logic [4:0]        dest_q [DEPTH], dest_d [DEPTH];
    logic [31:0]       value_q [DEPTH], value_d [DEPTH];
    logic [31:0]       ld_value_q [DEPTH], ld_value_d [DEPTH];
    logic              done_q [DEPTH], done_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DISC_W-1:0] discard_q, discard_d;

    logic [PTR_W-1:0]  slot_idx [DEPTH];
    logic [DEPTH-1:0]  slot_undone;
    logic              pend_found;
    logic [PTR_W-1:0]  pend_idx;
    logic [CNT_W-1:0]  undone_cnt;
    logic [31:0]       ext_value;
    logic              resp_hit, resp_drop, enq, retire, head_done;

    function automatic logic [31:0] extract(input logic [2:0] mode, input logic [1:0] a,
                                            input logic [31:0] rd, input logic [31:0] ld);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (mode)
            3'b010: case (a)
                2'd0:    r = {rd[7:0], ld[23:0]};
                2'd1:    r = {rd[15:0], ld[15:0]};
                2'd2:    r = {rd[23:0], ld[7:0]};
                default: r = rd;
            endcase
            3'b011: case (a)
                2'd0:    r = rd;
                2'd1:    r = {ld[31:24], rd[31:8]};
                2'd2:    r = {ld[31:16], rd[31:16]};
                default: r = {ld[31:8], rd[31:24]};
            endcase
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            3'b110:  r = {{24{b[7]}}, b};
            3'b111:  r = {{16{h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // Slot gi is the gi-th oldest live entry; it is undone only if it is a load awaiting data.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign slot_idx[gi]    = head_q + PTR_W'(gi);
        assign slot_undone[gi] = (CNT_W'(gi) < count_q) && !done_q[slot_idx[gi]];
    end

    always_comb begin
        pend_found = 1'b0;
        pend_idx   = head_q;
        undone_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_undone[i]) begin
                undone_cnt = undone_cnt + CNT_W'(1);
                if (!pend_found) begin
                    pend_found = 1'b1;
                    pend_idx   = slot_idx[i];
                end
            end
        end
    end

    assign ext_value = extract(op_q[pend_idx][6:4], value_q[pend_idx][1:0], resp_rdata, ld_value_q[pend_idx]);
    assign resp_drop = resp_valid && (discard_q != '0);
    assign resp_hit  = resp_valid && (discard_q == '0) && pend_found;
    assign head_done = (count_q != '0) && done_q[head_q];

    assign out_pc   = pc_q[head_q];
    assign out_inst = inst_q[head_q];
    assign out_op   = op_q[head_q];
    assign out_dest = dest_q[head_q];
`ifdef MEM_RESP_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = resp_hit && (pend_idx == head_q);
    assign out_valid  = head_done || bypass_hit;
    assign out_value  = bypass_hit ? ext_value : value_q[head_q];
`else
    assign out_valid  = head_done;
    assign out_value  = value_q[head_q];
`endif

    assign retire     = out_valid && wb_allowin;
    assign in_allowin = !flush && ((count_q < CNT_W'(DEPTH)) || retire);
    assign enq        = in_valid && in_allowin;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            pc_d[i]       = pc_q[i];
            inst_d[i]     = inst_q[i];
            op_d[i]       = op_q[i];
            dest_d[i]     = dest_q[i];
            value_d[i]    = value_q[i];
            ld_value_d[i] = ld_value_q[i];
            done_d[i]     = done_q[i];
        end
        head_d    = retire ? head_q + PTR_W'(1) : head_q;
        tail_d    = enq ? tail_q + PTR_W'(1) : tail_q;
        count_d   = count_q + CNT_W'(enq) - CNT_W'(retire);
        discard_d = resp_drop ? discard_q - DISC_W'(1) : discard_q;
        if (resp_hit) begin
            value_d[pend_idx] = ext_value;
            done_d[pend_idx]  = 1'b1;
        end
        // Enqueue last: when full and retiring, the tail slot is the departing head.
        if (enq) begin
            pc_d[tail_q]       = in_pc;
            inst_d[tail_q]     = in_inst;
            op_d[tail_q]       = in_op;
            dest_d[tail_q]     = in_dest;
            value_d[tail_q]    = in_value;
            ld_value_d[tail_q] = in_ld_value;
            done_d[tail_q]     = (in_op[6:4] == 3'b000);
        end
        // A same-cycle response belongs to the oldest owed load, so it cancels one discard.
        if (flush) begin
            head_d    = tail_q;
            count_d   = '0;
            discard_d = discard_q + DISC_W'(undone_cnt)
                        - DISC_W'(resp_valid && ((discard_q != '0) || pend_found));
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]       <= RESET_PC;
                inst_q[i]     <= '0;
                op_q[i]       <= '0;
                dest_q[i]     <= '0;
                value_q[i]    <= '0;
                ld_value_q[i] <= '0;
                done_q[i]     <= 1'b0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            discard_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]       <= pc_d[i];
                inst_q[i]     <= inst_d[i];
                op_q[i]       <= op_d[i];
                dest_q[i]     <= dest_d[i];
                value_q[i]    <= value_d[i];
                ld_value_q[i] <= ld_value_d[i];
                done_q[i]     <= done_d[i];
            end
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            discard_q <= discard_d;
        end
    end
endmodule

// File: tb/tb_mem_load_queue_stage.sv
// Self-checking bench for mem_load_queue_stage (default build): directed scenarios plus randomized traffic against a queue-level model.
module tb_mem_load_queue_stage;
    localparam int          DEPTH    = 4;
    localparam int          OP_W     = 20;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    logic            clk, resetn;
    logic            in_valid, in_allowin;
    logic [31:0]     in_pc, in_inst, in_value, in_ld_value;
    logic [OP_W-1:0] in_op;
    logic [4:0]      in_dest;
    logic            resp_valid;
    logic [31:0]     resp_rdata;
    logic            out_valid;
    logic [31:0]     out_pc, out_inst, out_value;
    logic [OP_W-1:0] out_op;
    logic [4:0]      out_dest;
    logic            wb_allowin, flush;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0]     pc, inst, value, ld;
        logic [OP_W-1:0] op;
        logic [4:0]      dest;
        bit              done;
    } ent_t;
    ent_t mq[$];
    int   m_disc;

    typedef struct {
        logic [2:0]  mode;
        logic [1:0]  a;
        logic [31:0] ld, rd, exp;
    } ext_t;
    ext_t ext_tab[7];

    mem_load_queue_stage #(.DEPTH(DEPTH), .OP_W(OP_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_allowin(in_allowin),
        .in_pc(in_pc), .in_inst(in_inst), .in_op(in_op), .in_dest(in_dest),
        .in_value(in_value), .in_ld_value(in_ld_value),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_op(out_op),
        .out_dest(out_dest), .out_value(out_value),
        .wb_allowin(wb_allowin), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OP_W-1:0] mk_op(input logic [2:0] mode);
        logic [OP_W-1:0] op;
        op      = '0;
        op[6:4] = mode;
        return op;
    endfunction

    // Extraction written from the shift/mask description of each load type.
    function automatic logic [31:0] ref_extract(input logic [2:0] mode, input logic [1:0] a,
                                                input logic [31:0] rd, input logic [31:0] ld);
        longint unsigned r64, l64;
        int sh;
        logic signed [7:0]  sb;
        logic signed [15:0] sh16;
        r64 = rd;
        l64 = ld;
        case (mode)
            3'd2: begin
                sh = 24 - 8 * int'(a);
                return 32'((r64 << sh) | (l64 & ((64'd1 << sh) - 1)));
            end
            3'd3: begin
                sh = 8 * int'(a);
                return 32'((l64 & ~((64'd1 << (32 - sh)) - 1)) | (r64 >> sh));
            end
            3'd4: return (rd >> (8 * int'(a))) & 32'hff;
            3'd5: return (rd >> (16 * int'(a[1]))) & 32'hffff;
            3'd6: begin
                sb = 8'(rd >> (8 * int'(a)));
                return 32'(int'(sb));
            end
            3'd7: begin
                sh16 = 16'(rd >> (16 * int'(a[1])));
                return 32'(int'(sh16));
            end
            default: return rd;
        endcase
    endfunction

    function automatic int model_undone();
        int n = 0;
        foreach (mq[i]) if (!mq[i].done) n++;
        return n;
    endfunction

    task automatic idle_inputs();
        in_valid = 0; in_pc = 0; in_inst = 0; in_op = '0; in_dest = 0;
        in_value = 0; in_ld_value = 0; resp_valid = 0; resp_rdata = 0;
        wb_allowin = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 0;
        step();
        resetn = 1;
        mq.delete();
        m_disc = 0;
    endtask

    task automatic drive_entry(input logic [31:0] pc, input logic [2:0] mode,
                               input logic [31:0] value, input logic [31:0] ld);
        in_valid = 1; in_pc = pc; in_inst = pc ^ 32'h5a5a0000; in_op = mk_op(mode);
        in_dest = pc[6:2]; in_value = value; in_ld_value = ld;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (in_allowin !== 1'b1) begin failures++; $display("FAIL reset_in_allowin got=%b want=1", in_allowin); end
        checks++; if (out_pc !== RESET_PC) begin failures++; $display("FAIL reset_out_pc got=%h want=%h", out_pc, RESET_PC); end
        checks++; if (out_value !== 32'h0) begin failures++; $display("FAIL reset_out_value got=%h want=0", out_value); end
        $display("txn reset out_pc=%h", out_pc);
    endtask

    task automatic test_nonload();
        do_reset();
        wb_allowin = 1;
        drive_entry(32'h100, 3'b000, 32'h1234, 32'h0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_allowin !== 1'b1) begin failures++; $display("FAIL nonload_c1 got ov=%b allow=%b want ov=0 allow=1", out_valid, in_allowin); end
        step();
        in_valid = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_value !== 32'h1234 || out_pc !== 32'h100) begin failures++; $display("FAIL nonload_c2 got ov=%b val=%h pc=%h want ov=1 val=00001234 pc=00000100", out_valid, out_value, out_pc); end
        step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || dut.count_q !== '0) begin failures++; $display("FAIL nonload_c3 got ov=%b count=%0d want ov=0 count=0", out_valid, dut.count_q); end
        $display("txn nonload value=%h", 32'h1234);
    endtask

    task automatic test_extract();
        ext_tab[0] = '{3'b110, 2'd2, 32'h0,        32'h8899aabb, 32'hffffff99};
        ext_tab[1] = '{3'b100, 2'd2, 32'h0,        32'h8899aabb, 32'h00000099};
        ext_tab[2] = '{3'b111, 2'd2, 32'h0,        32'h8899aabb, 32'hffff8899};
        ext_tab[3] = '{3'b101, 2'd0, 32'h0,        32'h8899aabb, 32'h0000aabb};
        ext_tab[4] = '{3'b010, 2'd1, 32'h11223344, 32'haabbccdd, 32'hccdd3344};
        ext_tab[5] = '{3'b011, 2'd2, 32'h11223344, 32'haabbccdd, 32'h1122aabb};
        ext_tab[6] = '{3'b001, 2'd3, 32'h11223344, 32'h0badf00d, 32'h0badf00d};
        for (int i = 0; i < 7; i++) begin
            do_reset();
            wb_allowin = 1;
            drive_entry(32'h200 + 32'(4 * i), ext_tab[i].mode, {30'h400, ext_tab[i].a}, ext_tab[i].ld);
            step();
            in_valid = 0;
            resp_valid = 1;
            resp_rdata = ext_tab[i].rd;
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL extract_wait[%0d] got ov=%b want ov=0", i, out_valid); end
            step();
            resp_valid = 0;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_value !== ext_tab[i].exp) begin failures++; $display("FAIL extract[%0d] mode=%0d a=%0d got ov=%b val=%h want ov=1 val=%h", i, ext_tab[i].mode, ext_tab[i].a, out_valid, out_value, ext_tab[i].exp); end
            $display("txn extract mode=%0d a=%0d value=%h", ext_tab[i].mode, ext_tab[i].a, out_value);
            step();
        end
    endtask

    task automatic test_ordering();
        do_reset();
        wb_allowin = 1;
        drive_entry(32'h300, 3'b001, 32'h2000, 32'h0); step();
        drive_entry(32'h304, 3'b000, 32'h55, 32'h0);   step();
        drive_entry(32'h308, 3'b001, 32'h2004, 32'h0); step();
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL order_hold[%0d] got ov=%b want ov=0", i, out_valid); end
            step();
        end
        resp_valid = 1; resp_rdata = 32'ha1a1a1a1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL order_resp1 got ov=%b want ov=0", out_valid); end
        step();
        resp_valid = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_value !== 32'ha1a1a1a1) begin failures++; $display("FAIL order_lw1 got ov=%b pc=%h val=%h want ov=1 pc=00000300 val=a1a1a1a1", out_valid, out_pc, out_value); end
        step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h304 || out_value !== 32'h55) begin failures++; $display("FAIL order_addu got ov=%b pc=%h val=%h want ov=1 pc=00000304 val=00000055", out_valid, out_pc, out_value); end
        step();
        resp_valid = 1; resp_rdata = 32'hb2b2b2b2;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL order_wait2 got ov=%b want ov=0", out_valid); end
        step();
        resp_valid = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h308 || out_value !== 32'hb2b2b2b2) begin failures++; $display("FAIL order_lw2 got ov=%b pc=%h val=%h want ov=1 pc=00000308 val=b2b2b2b2", out_valid, out_pc, out_value); end
        step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL order_empty got ov=%b want ov=0", out_valid); end
        $display("txn ordering done");
    endtask

    task automatic test_full();
        do_reset();
        wb_allowin = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_entry(32'h400 + 32'(4 * i), 3'b000, 32'(10 + i), 32'h0);
            @(negedge clk);
            checks++; if (in_allowin !== 1'b1) begin failures++; $display("FAIL full_fill[%0d] got allow=%b want 1", i, in_allowin); end
            step();
        end
        drive_entry(32'h410, 3'b000, 32'(10 + DEPTH), 32'h0);
        @(negedge clk);
        checks++; if (in_allowin !== 1'b0 || out_valid !== 1'b1 || out_value !== 32'd10) begin failures++; $display("FAIL full_block got allow=%b ov=%b val=%h want allow=0 ov=1 val=0000000a", in_allowin, out_valid, out_value); end
        step();
        wb_allowin = 1;
        @(negedge clk);
        checks++; if (in_allowin !== 1'b1) begin failures++; $display("FAIL full_retire_enq got allow=%b want 1", in_allowin); end
        step();
        in_valid = 0;
        @(negedge clk);
        checks++; if (dut.count_q !== 3'(DEPTH)) begin failures++; $display("FAIL full_count got=%0d want=%0d", dut.count_q, DEPTH); end
        for (int k = 1; k <= DEPTH; k++) begin
            checks++; if (out_valid !== 1'b1 || out_value !== 32'(10 + k)) begin failures++; $display("FAIL full_drain[%0d] got ov=%b val=%h want ov=1 val=%h", k, out_valid, out_value, 32'(10 + k)); end
            step();
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_empty got ov=%b want 0", out_valid); end
        $display("txn full/backpressure done");
    endtask

    task automatic test_flush();
        do_reset();
        wb_allowin = 1;
        drive_entry(32'h500, 3'b001, 32'h3000, 32'h0); step();
        drive_entry(32'h504, 3'b001, 32'h3004, 32'h0); step();
        drive_entry(32'h508, 3'b000, 32'h77, 32'h0);
        flush = 1;
        @(negedge clk);
        checks++; if (in_allowin !== 1'b0) begin failures++; $display("FAIL flush_block got allow=%b want 0", in_allowin); end
        step();
        flush = 0; in_valid = 0;
        @(negedge clk);
        checks++; if (dut.discard_q !== 8'd2 || out_valid !== 1'b0 || dut.count_q !== '0) begin failures++; $display("FAIL flush_state got disc=%0d ov=%b count=%0d want disc=2 ov=0 count=0", dut.discard_q, out_valid, dut.count_q); end
        drive_entry(32'h50c, 3'b001, 32'h3008, 32'h0);
        resp_valid = 1; resp_rdata = 32'hdead0001;
        step();
        in_valid = 0; resp_rdata = 32'hdead0002;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop got ov=%b want 0", out_valid); end
        step();
        resp_rdata = 32'hcafebabe;
        @(negedge clk);
        checks++; if (dut.discard_q !== 8'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_drained got disc=%0d ov=%b want disc=0 ov=0", dut.discard_q, out_valid); end
        step();
        resp_valid = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h50c || out_value !== 32'hcafebabe) begin failures++; $display("FAIL flush_newload got ov=%b pc=%h val=%h want ov=1 pc=0000050c val=cafebabe", out_valid, out_pc, out_value); end
        step();
        $display("txn flush done");
    endtask

    task automatic test_random();
        bit   exp_ov, exp_allow, enq, ret;
        int   outstanding, u;
        ent_t e;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            outstanding  = m_disc + model_undone();
            in_valid     = 1'($urandom_range(0, 1));
            in_pc        = $urandom;
            in_inst      = $urandom;
            in_op        = OP_W'($urandom);
            in_op[6:4]   = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
            in_dest      = 5'($urandom);
            in_value     = $urandom;
            in_ld_value  = $urandom;
            wb_allowin   = ($urandom_range(0, 3) != 0);
            resp_valid   = (outstanding > 0) && ($urandom_range(0, 2) == 0);
            resp_rdata   = $urandom;
            flush        = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            exp_ov    = (mq.size() > 0) && mq[0].done;
            exp_allow = !flush && ((mq.size() < DEPTH) || (exp_ov && wb_allowin));
            checks++; if (out_valid !== exp_ov) begin failures++; $display("FAIL rand_out_valid cyc=%0d got=%b want=%b", n, out_valid, exp_ov); end
            checks++; if (in_allowin !== exp_allow) begin failures++; $display("FAIL rand_in_allowin cyc=%0d got=%b want=%b", n, in_allowin, exp_allow); end
            if (exp_ov) begin
                checks++;
                if ({out_pc, out_inst, out_op, out_dest, out_value} !== {mq[0].pc, mq[0].inst, mq[0].op, mq[0].dest, mq[0].value}) begin
                    failures++;
                    $display("FAIL rand_head cyc=%0d got pc=%h val=%h dest=%0d want pc=%h val=%h dest=%0d", n, out_pc, out_value, out_dest, mq[0].pc, mq[0].value, mq[0].dest);
                end
            end
            enq = in_valid && exp_allow;
            ret = exp_ov && wb_allowin;
            if (ret) $display("txn retire cyc=%0d pc=%h value=%h", n, mq[0].pc, mq[0].value);
            if (flush) begin
                u      = model_undone();
                m_disc = m_disc + u - (resp_valid ? 1 : 0);
                mq.delete();
            end else begin
                if (resp_valid) begin
                    if (m_disc > 0) m_disc--;
                    else begin
                        for (int k = 0; k < mq.size(); k++) begin
                            if (!mq[k].done) begin
                                mq[k].value = ref_extract(mq[k].op[6:4], mq[k].value[1:0], resp_rdata, mq[k].ld);
                                mq[k].done  = 1;
                                break;
                            end
                        end
                    end
                end
                if (ret) void'(mq.pop_front());
                if (enq) begin
                    e.pc = in_pc; e.inst = in_inst; e.op = in_op; e.dest = in_dest;
                    e.value = in_value; e.ld = in_ld_value; e.done = (in_op[6:4] == 3'd0);
                    mq.push_back(e);
                end
            end
            step();
        end
    endtask

    initial begin
        resetn = 0;
        idle_inputs();
        test_reset();
        test_nonload();
        test_extract();
        test_ordering();
        test_full();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
